// File: rtl/pontuacao_pkg.sv
// Shared constants and state encoding for the round evaluator feeding
// calculadora_pontos.
package pontuacao_pkg;

    localparam int NOTE_W  = 4;
    localparam int ROUND_W = 4;
    localparam int ERR_W   = 8;

    typedef logic [2:0] estado_t;

    localparam estado_t OCIOSO    = 3'd0;
    localparam estado_t ESPERA    = 3'd1;
    localparam estado_t REGISTRA  = 3'd2;
    localparam estado_t FIM       = 3'd3;
    localparam estado_t CALCULA   = 3'd4;
    localparam estado_t CONCLUIDO = 3'd5;

endpackage

// File: rtl/contador_erros_rodada.sv
// Per-round error counter: synchronous clear at round start, +1 per wrong note.
module contador_erros_rodada #(
    parameter int ERR_W = pontuacao_pkg::ERR_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             limpar,
    input  logic             incrementar,
    output logic [ERR_W-1:0] valor
);

    localparam logic [ERR_W-1:0] UM = ERR_W'(1);

    logic [ERR_W-1:0] valor_q;
    logic [ERR_W-1:0] valor_d;

    // A round holds at most 16 notes, so the count never approaches wrap.
    always_comb begin
        valor_d = valor_q;
        if (limpar) begin
            valor_d = '0;
        end else if (incrementar) begin
            valor_d = valor_q + UM;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign valor = valor_q;

endmodule

// File: rtl/avaliador_rodada.sv
// Round evaluator: walks the expected note sequence, counts wrong/missed notes
// and issues a one-cycle calcular strobe to calculadora_pontos at round end.
module avaliador_rodada #(
    parameter int NOTE_W  = pontuacao_pkg::NOTE_W,
    parameter int ROUND_W = pontuacao_pkg::ROUND_W,
    parameter int ERR_W   = pontuacao_pkg::ERR_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic [ROUND_W-1:0] rodada,
    input  logic               nota_valida,
    input  logic [NOTE_W-1:0]  nota_jogada,
    input  logic               timeout,
    input  logic [NOTE_W-1:0]  nota_esperada,
    output logic [ROUND_W-1:0] endereco,
    output logic [ERR_W-1:0]   erros,
    output logic [ROUND_W-1:0] rodada_out,
    output logic               calcular,
    output logic               ocupado,
    output logic               pronto
);

    import pontuacao_pkg::*;

    localparam logic [ROUND_W-1:0] UM = ROUND_W'(1);

    estado_t            estado_q,   estado_d;
    logic [ROUND_W-1:0] endereco_q, endereco_d;
    logic [ROUND_W-1:0] rodada_q,   rodada_d;
    logic               erro_q,     erro_d;
    logic               limpar;
    logic               incrementar;

    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    always_comb begin
        estado_d    = estado_q;
        endereco_d  = endereco_q;
        rodada_d    = rodada_q;
        erro_d      = erro_q;
        limpar      = 1'b0;
        incrementar = 1'b0;

        case (estado_q)
            OCIOSO, CONCLUIDO: begin
                if (iniciar) begin
                    rodada_d   = rodada;
                    endereco_d = '0;
                    limpar     = 1'b1;
                    estado_d   = ESPERA;
                end
            end
            ESPERA: begin
                // A played note takes priority over a simultaneous timeout.
                if (nota_valida) begin
                    erro_d   = (nota_jogada != nota_esperada);
                    estado_d = REGISTRA;
                end else if (timeout) begin
                    erro_d   = 1'b1;
                    estado_d = REGISTRA;
                end
            end
            REGISTRA: begin
                incrementar = erro_q;
                if (endereco_q == rodada_q) begin
                    estado_d = FIM;
                end else begin
                    endereco_d = endereco_q + UM;
                    estado_d   = ESPERA;
                end
            end
            FIM:     estado_d = CALCULA;
            CALCULA: estado_d = CONCLUIDO;
            default: estado_d = OCIOSO;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            endereco_q <= '0;
            rodada_q   <= '0;
            erro_q     <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            rodada_q   <= rodada_d;
            erro_q     <= erro_d;
        end
    end

    contador_erros_rodada #(
        .ERR_W(ERR_W)
    ) u_contador (
        .clock      (clock),
        .reset      (reset),
        .limpar     (limpar),
        .incrementar(incrementar),
        .valor      (erros)
    );

    assign endereco   = endereco_q;
    assign rodada_out = rodada_q;
    assign calcular   = (estado_q == CALCULA);
    assign pronto     = (estado_q == CONCLUIDO);
    assign ocupado    = (estado_q == ESPERA) || (estado_q == REGISTRA) ||
                        (estado_q == FIM)    || (estado_q == CALCULA);

endmodule

// File: tb/tb_avaliador_rodada.sv
// Scoreboard bench for avaliador_rodada: expected erros/rodada pushed per round,
// popped and compared on each calcular strobe.
module tb_avaliador_rodada;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       nota_valida = 1'b0;
    logic       timeout = 1'b0;
    logic [3:0] rodada = 4'd0;
    logic [3:0] nota_jogada = 4'd0;
    logic [3:0] nota_esperada;
    logic [3:0] endereco;
    logic [3:0] rodada_out;
    logic [7:0] erros;
    logic       calcular;
    logic       ocupado;
    logic       pronto;

    logic [3:0] mem [16];

    typedef struct packed {
        logic [7:0] erros;
        logic [3:0] rodada;
    } exp_t;

    exp_t sb[$];
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clock = ~clock;

    assign nota_esperada = mem[endereco];

    avaliador_rodada dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .rodada       (rodada),
        .nota_valida  (nota_valida),
        .nota_jogada  (nota_jogada),
        .timeout      (timeout),
        .nota_esperada(nota_esperada),
        .endereco     (endereco),
        .erros        (erros),
        .rodada_out   (rodada_out),
        .calcular     (calcular),
        .ocupado      (ocupado),
        .pronto       (pronto)
    );

    task automatic push_exp(input logic [7:0] e, input logic [3:0] r);
        exp_t x;
        x.erros  = e;
        x.rodada = r;
        sb.push_back(x);
    endtask

    task automatic start_round(input logic [3:0] r);
        @(negedge clock);
        iniciar = 1'b1;
        rodada  = r;
        @(negedge clock);
        iniciar = 1'b0;
        n_chk++;
        if (rodada_out !== r || endereco !== 4'd0 || erros !== 8'd0 ||
            ocupado !== 1'b1 || pronto !== 1'b0) begin
            n_err++;
            $display("FAIL start_round r=%0d: rodada_out=%0d endereco=%0d erros=%0d ocupado=%b pronto=%b, required %0d 0 0 1 0",
                     r, rodada_out, endereco, erros, ocupado, pronto, r);
        end
    endtask

    // Called at a negedge with the DUT in ESPERA; returns two cycles later.
    task automatic drive_note(input logic [3:0] jog, input logic nv,
                              input logic tmo, input int idx);
        n_chk++;
        if (endereco !== idx[3:0] || ocupado !== 1'b1) begin
            n_err++;
            $display("FAIL note_addr idx=%0d: endereco=%0d ocupado=%b, required %0d 1",
                     idx, endereco, ocupado, idx);
        end
        nota_jogada = jog;
        nota_valida = nv;
        timeout     = tmo;
        @(negedge clock);
        nota_valida = 1'b0;
        timeout     = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_calcular(input string nome, output int espera);
        logic [7:0] prev_e;
        logic [3:0] prev_r;
        exp_t       x;
        bit         visto;
        visto  = 1'b0;
        espera = 0;
        prev_e = erros;
        prev_r = rodada_out;
        for (int i = 0; i < 20 && !visto; i++) begin
            @(negedge clock);
            espera++;
            if (calcular === 1'b1) begin
                visto = 1'b1;
            end else begin
                prev_e = erros;
                prev_r = rodada_out;
            end
        end
        n_chk++;
        if (!visto) begin
            n_err++;
            $display("FAIL %s calcular: not seen within 20 cycles, required a pulse", nome);
        end
        if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s scoreboard: queue empty, required one entry", nome);
        end else begin
            x = sb.pop_front();
            if (visto) begin
                n_chk++;
                if (erros !== x.erros || rodada_out !== x.rodada) begin
                    n_err++;
                    $display("FAIL %s result: erros=%0d rodada_out=%0d, required %0d %0d",
                             nome, erros, rodada_out, x.erros, x.rodada);
                end
                n_chk++;
                if (prev_e !== erros || prev_r !== rodada_out) begin
                    n_err++;
                    $display("FAIL %s stable_before: prior erros=%0d rodada_out=%0d, required %0d %0d",
                             nome, prev_e, prev_r, erros, rodada_out);
                end
                @(negedge clock);
                n_chk++;
                if (calcular !== 1'b0 || erros !== x.erros || rodada_out !== x.rodada ||
                    pronto !== 1'b1 || ocupado !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s after: calcular=%b erros=%0d rodada_out=%0d pronto=%b ocupado=%b, required 0 %0d %0d 1 0",
                             nome, calcular, erros, rodada_out, pronto, ocupado, x.erros, x.rodada);
                end
            end
        end
    endtask

    task automatic test_reset();
        int pulsos;
        n_chk++;
        if (endereco !== 4'd0 || erros !== 8'd0 || rodada_out !== 4'd0 ||
            calcular !== 1'b0 || ocupado !== 1'b0 || pronto !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: endereco=%0d erros=%0d rodada_out=%0d calcular=%b ocupado=%b pronto=%b, required all 0",
                     endereco, erros, rodada_out, calcular, ocupado, pronto);
        end
        start_round(4'd3);
        drive_note(~mem[0], 1'b1, 1'b0, 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_chk++;
        if (endereco !== 4'd0 || erros !== 8'd0 || rodada_out !== 4'd0 ||
            calcular !== 1'b0 || ocupado !== 1'b0 || pronto !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_round: endereco=%0d erros=%0d rodada_out=%0d calcular=%b ocupado=%b pronto=%b, required all 0",
                     endereco, erros, rodada_out, calcular, ocupado, pronto);
        end
        pulsos = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (calcular !== 1'b0) pulsos++;
        end
        n_chk++;
        if (pulsos != 0) begin
            n_err++;
            $display("FAIL reset_no_calcular: pulses=%0d, required 0", pulsos);
        end
    endtask

    task automatic test_single_note();
        int espera;
        start_round(4'd0);
        drive_note(mem[0], 1'b1, 1'b0, 0);
        push_exp(8'd0, 4'd0);
        wait_calcular("single", espera);
        n_chk++;
        if (espera != 1) begin
            n_err++;
            $display("FAIL single_latency: cycles=%0d, required 1 after note return", espera);
        end
    endtask

    task automatic test_mixed_notes();
        int espera;
        start_round(4'd3);
        drive_note(mem[0], 1'b1, 1'b0, 0);
        drive_note(~mem[1], 1'b1, 1'b0, 1);
        drive_note(4'd0, 1'b0, 1'b1, 2);
        drive_note(mem[3], 1'b1, 1'b0, 3);
        push_exp(8'd2, 4'd3);
        wait_calcular("mixed", espera);
        nota_jogada = ~mem[3];
        nota_valida = 1'b1;
        @(negedge clock);
        nota_valida = 1'b0;
        repeat (3) @(negedge clock);
        n_chk++;
        if (endereco !== 4'd3 || erros !== 8'd2 || pronto !== 1'b1 || calcular !== 1'b0) begin
            n_err++;
            $display("FAIL mixed_extra_note: endereco=%0d erros=%0d pronto=%b calcular=%b, required 3 2 1 0",
                     endereco, erros, pronto, calcular);
        end
    endtask

    task automatic test_max_round();
        int espera;
        start_round(4'd15);
        for (int i = 0; i < 16; i++) drive_note(~mem[i], 1'b1, 1'b0, i);
        push_exp(8'h10, 4'd15);
        wait_calcular("max", espera);
        n_chk++;
        if (endereco !== 4'd15) begin
            n_err++;
            $display("FAIL max_endereco: endereco=%0d, required 15", endereco);
        end
    endtask

    task automatic test_priority_and_iniciar();
        int espera;
        start_round(4'd1);
        drive_note(mem[0], 1'b1, 1'b1, 0);
        iniciar = 1'b1;
        rodada  = 4'd9;
        @(negedge clock);
        iniciar = 1'b0;
        n_chk++;
        if (rodada_out !== 4'd1 || endereco !== 4'd1 || erros !== 8'd0 || ocupado !== 1'b1) begin
            n_err++;
            $display("FAIL iniciar_ignored: rodada_out=%0d endereco=%0d erros=%0d ocupado=%b, required 1 1 0 1",
                     rodada_out, endereco, erros, ocupado);
        end
        drive_note(~mem[1], 1'b1, 1'b0, 1);
        push_exp(8'd1, 4'd1);
        wait_calcular("priority", espera);
    endtask

    task automatic test_back_to_back();
        int espera;
        for (int r = 0; r < 16; r++) begin
            start_round(r[3:0]);
            for (int i = 0; i <= r; i++) drive_note(mem[i], 1'b1, 1'b0, i);
            push_exp(8'd0, r[3:0]);
            wait_calcular("chain", espera);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'((i * 3 + 5) % 16);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        test_reset();
        test_single_note();
        test_mixed_notes();
        test_max_round();
        test_priority_and_iniciar();
        test_back_to_back();
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: left=%0d, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/avaliador_rodada.md
Name: avaliador_rodada

Overview:
Upstream stage of calculadora_pontos. Per round it walks the expected note sequence, compares each player note (or timeout) against it and counts errors. At round end it presents erros/rodada and fires a single-cycle calcular pulse that the score calculator samples. It sits between the input/sequence-memory logic and calculadora_pontos.

Parameters:
NOTE_W, 4, width of a note code (nota_jogada, nota_esperada)
ROUND_W, 4, width of round index; round r contains r+1 notes
ERR_W, 8, width of erros (matches calculadora_pontos erros input)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
iniciar  in  1  start-round request; accepted only in OCIOSO or CONCLUIDO
rodada  in  ROUND_W  round index, latched on accepted iniciar
nota_valida  in  1  player note event (edge-detected upstream)
nota_jogada  in  NOTE_W  note played, valid with nota_valida
timeout  in  1  player response timer expired for current note
nota_esperada  in  NOTE_W  sequence memory data at endereco, stable while endereco is stable
endereco  out  ROUND_W  index of the note currently expected
erros  out  ERR_W  error count of current/last round
rodada_out  out  ROUND_W  latched round index, drives calculadora_pontos.rodada
calcular  out  1  one-cycle pulse, score calculation strobe
ocupado  out  1  round in progress
pronto  out  1  round evaluated, score strobe issued

Behaviour:
- Reset (sync, active-high, wins over everything): state OCIOSO; endereco=0, erros=0, rodada_out=0, calcular=0, ocupado=0, pronto=0. Reset mid-round aborts with no calcular pulse.
- All outputs registered or decoded from state (Moore); no combinational input-to-output paths.
- States: OCIOSO, ESPERA, REGISTRA, FIM, CALCULA, CONCLUIDO.
- OCIOSO/CONCLUIDO + iniciar=1: rodada_out<=rodada, erros<=0, endereco<=0, pronto<=0 -> ESPERA. iniciar ignored in all other states.
- ESPERA (ocupado=1): on nota_valida=1 or timeout=1, capture error flag = timeout | (nota_jogada != nota_esperada) -> REGISTRA. Simultaneous nota_valida and timeout: note is compared (nota_valida priority), timeout dropped.
- REGISTRA (1 cycle, all inputs ignored): erros<=erros+flag. If endereco==rodada_out -> FIM, else endereco<=endereco+1 -> ESPERA.
- FIM (1 cycle): erros/rodada_out stable one full cycle before strobe -> CALCULA.
- CALCULA: calcular=1 for exactly one cycle -> CONCLUIDO.
- CONCLUIDO: pronto=1, ocupado=0; erros, rodada_out, endereco held until next accepted iniciar.
- Latency: note event in cycle N -> calcular high in cycle N+3 for the last note; min round length (rodada=0) from iniciar cycle T with note at T+1: calcular at T+4.
- erros/rodada_out never change while calcular=1 or in the cycle after.
- Width: max 16 notes per round -> erros <= 16, no overflow possible at ERR_W=8; add is plain unsigned.
- rodada=15: endereco runs 0..15, no wrap; comparison endereco==rodada_out ends the round before any increment past 15.
- nota_valida held high: one note per ESPERA visit (at most one every 2 cycles); upstream guarantees single-cycle pulses.

Decomposition:
- Shared package (pontuacao_pkg): NOTE_W, ROUND_W, ERR_W constants; state encoding typedef for avaliador_rodada.
- One sub-module: contador_erros_rodada (clear, inc-enable, ERR_W counter) instantiated once; comparison and FSM stay in top.

Test Plan:
- Reset in ESPERA of round 3 -> next cycle state OCIOSO, all outputs 0, no calcular ever seen.
- rodada=0, iniciar, one correct note (jogada=esperada=4'h5) -> calcular single pulse 3 cycles after note, erros=0, rodada_out=0, pronto=1 after.
- rodada=3, notes: correct, wrong, timeout, correct -> endereco steps 0,1,2,3; erros=2 at calcular; exactly 4 notes consumed.
- rodada=15, all 16 notes wrong -> erros=16 (8'h10), endereco stops at 15, one calcular pulse.
- nota_valida and timeout asserted same cycle with correct note -> no error counted; iniciar pulsed mid-round -> ignored, rodada_out unchanged.
- Chain with calculadora_pontos, rounds 0..15 all correct -> pontos_out matches calculadora reference sequence; erros/rodada_out stable across every calcular edge.
